// File: rtl/adder_tree_accumulator.sv
// Accumulates the adder tree's final sum over a beat sequence delimited by last,
// with signed saturation, a one-deep pending slot and a registered stall to the feeder.
module adder_tree_accumulator #(
    parameter int ACC_BW   = 32,
    parameter int TREE_LAT = 2,
    parameter int CNT_BW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tree_valid_in,
    input  logic              tree_last_in,
    input  logic [ACC_BW-1:0] tree_sum,
    output logic              stall,
    output logic [ACC_BW-1:0] out_data,
    output logic [CNT_BW-1:0] out_cnt,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              drop_err
);

    localparam logic [ACC_BW:0] SUM_MAX = {2'b00, {(ACC_BW-1){1'b1}}};
    localparam logic [ACC_BW:0] SUM_MIN = {2'b11, {(ACC_BW-1){1'b0}}};

    logic [TREE_LAT-1:0] r_vld_dly;
    logic [TREE_LAT-1:0] r_last_dly;

    logic [ACC_BW-1:0] r_acc, w_acc_next;
    logic [CNT_BW-1:0] r_cnt, w_cnt_next;
    logic              r_sat, w_sat_next;
    logic              r_pend, w_pend_next;
    logic [ACC_BW-1:0] r_out_data, w_out_data_next;
    logic [CNT_BW-1:0] r_out_cnt, w_out_cnt_next;
    logic              r_out_sat, w_out_sat_next;
    logic              r_out_valid, w_out_valid_next;
    logic              r_drop_err, w_drop_err_next;
    logic              r_stall, w_stall_next;

    logic              w_a_valid;
    logic              w_a_last;
    logic              w_drain;
    logic [ACC_BW:0]   w_sum_ext;
    logic              w_ovf;
    logic [ACC_BW-1:0] w_beat_acc;
    logic [CNT_BW-1:0] w_beat_cnt;
    logic              w_beat_sat;

    // Sideband delay line; last is stored pre-qualified by valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_dly[0]  <= 1'b0;
            r_last_dly[0] <= 1'b0;
        end else begin
            r_vld_dly[0]  <= tree_valid_in;
            r_last_dly[0] <= tree_valid_in & tree_last_in;
        end
    end

    generate
        for (genvar gi = 1; gi < TREE_LAT; gi++) begin : g_dly
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_dly[gi]  <= 1'b0;
                    r_last_dly[gi] <= 1'b0;
                end else begin
                    r_vld_dly[gi]  <= r_vld_dly[gi-1];
                    r_last_dly[gi] <= r_last_dly[gi-1];
                end
            end
        end
    endgenerate

    assign w_a_valid = r_vld_dly[TREE_LAT-1];
    assign w_a_last  = r_last_dly[TREE_LAT-1];
    assign w_drain   = r_out_valid & out_ready;

    // One extra bit of headroom; top two bits disagreeing means the sum left the range.
    always_comb begin
        if (r_cnt == '0)
            w_sum_ext = {tree_sum[ACC_BW-1], tree_sum};
        else
            w_sum_ext = {r_acc[ACC_BW-1], r_acc} + {tree_sum[ACC_BW-1], tree_sum};
        w_ovf = w_sum_ext[ACC_BW] ^ w_sum_ext[ACC_BW-1];
        if (!w_ovf)
            w_beat_acc = w_sum_ext[ACC_BW-1:0];
        else if (w_sum_ext[ACC_BW])
            w_beat_acc = SUM_MIN[ACC_BW-1:0];
        else
            w_beat_acc = SUM_MAX[ACC_BW-1:0];
        w_beat_sat = ((r_cnt == '0) ? 1'b0 : r_sat) | w_ovf;
        w_beat_cnt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_BW'(1);
    end

    always_comb begin
        w_acc_next       = r_acc;
        w_cnt_next       = r_cnt;
        w_sat_next       = r_sat;
        w_pend_next      = r_pend;
        w_out_data_next  = r_out_data;
        w_out_cnt_next   = r_out_cnt;
        w_out_sat_next   = r_out_sat;
        w_out_valid_next = r_out_valid & ~out_ready;
        w_drop_err_next  = r_drop_err;

        if (r_pend) begin
            // Any beat arriving while a result is parked is lost.
            if (w_a_valid)
                w_drop_err_next = 1'b1;
            if (w_drain) begin
                w_out_data_next  = r_acc;
                w_out_cnt_next   = r_cnt;
                w_out_sat_next   = r_sat;
                w_out_valid_next = 1'b1;
                w_acc_next       = '0;
                w_cnt_next       = '0;
                w_sat_next       = 1'b0;
                w_pend_next      = 1'b0;
            end
        end else if (w_a_valid) begin
            if (w_a_last && (!r_out_valid || w_drain)) begin
                w_out_data_next  = w_beat_acc;
                w_out_cnt_next   = w_beat_cnt;
                w_out_sat_next   = w_beat_sat;
                w_out_valid_next = 1'b1;
                w_acc_next       = '0;
                w_cnt_next       = '0;
                w_sat_next       = 1'b0;
            end else begin
                w_acc_next  = w_beat_acc;
                w_cnt_next  = w_beat_cnt;
                w_sat_next  = w_beat_sat;
                w_pend_next = w_a_last;
            end
        end

        w_stall_next = w_out_valid_next | w_pend_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_pend      <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_drop_err  <= 1'b0;
            r_stall     <= 1'b0;
        end else begin
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_next;
            r_sat       <= w_sat_next;
            r_pend      <= w_pend_next;
            r_out_data  <= w_out_data_next;
            r_out_cnt   <= w_out_cnt_next;
            r_out_sat   <= w_out_sat_next;
            r_out_valid <= w_out_valid_next;
            r_drop_err  <= w_drop_err_next;
            r_stall     <= w_stall_next;
        end
    end

    assign stall     = r_stall;
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;
    assign out_sat   = r_out_sat;
    assign out_valid = r_out_valid;
    assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Directed bench for adder_tree_accumulator; models a 2-cycle adder tree in front of the DUT.
module tb_adder_tree_accumulator;

    localparam int ACC_BW   = 32;
    localparam int TREE_LAT = 2;
    localparam int CNT_BW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              tree_valid_in;
    logic              tree_last_in;
    logic [ACC_BW-1:0] tree_sum;
    logic              stall;
    logic [ACC_BW-1:0] out_data;
    logic [CNT_BW-1:0] out_cnt;
    logic              out_sat;
    logic              out_valid;
    logic              out_ready;
    logic              drop_err;

    logic [ACC_BW-1:0] sum_in;
    logic [ACC_BW-1:0] sum_s1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Adder tree stand-in: operand sum appears on tree_sum TREE_LAT cycles later.
    always @(posedge clk) begin
        sum_s1   <= sum_in;
        tree_sum <= sum_s1;
    end

    adder_tree_accumulator #(
        .ACC_BW  (ACC_BW),
        .TREE_LAT(TREE_LAT),
        .CNT_BW  (CNT_BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tree_valid_in(tree_valid_in),
        .tree_last_in (tree_last_in),
        .tree_sum     (tree_sum),
        .stall        (stall),
        .out_data     (out_data),
        .out_cnt      (out_cnt),
        .out_sat      (out_sat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .drop_err     (drop_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic l, input logic [ACC_BW-1:0] s);
        @(negedge clk);
        tree_valid_in = v;
        tree_last_in  = l;
        sum_in        = s;
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 1'b0, '0);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic [31:0] c, input logic s);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  out_data, d);
        chk({tag, "_cnt"},   32'(out_cnt), c);
        chk({tag, "_sat"},   32'(out_sat), 32'(s));
    endtask

    initial begin
        rst = 1'b1; tree_valid_in = 1'b0; tree_last_in = 1'b0; sum_in = '0; out_ready = 1'b1;
        idle(3);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_cnt",   32'(out_cnt), 32'd0);
        chk("rst_sat",   32'(out_sat), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_drop",  32'(drop_err), 32'd0);
        rst = 1'b0;
        idle(2);

        // Single beat: result visible 3 cycles after the valid beat.
        issue(1'b1, 1'b1, 32'd100);
        idle(2);
        chk("single_early", 32'(out_valid), 32'd0);
        idle(1);
        chk_out("single", 32'd100, 32'd1, 1'b0);
        chk("single_stall", 32'(stall), 32'd1);
        idle(1);
        chk("single_drained", 32'(out_valid), 32'd0);
        chk("single_stall_lo", 32'(stall), 32'd0);
        $display("txn single: data=%0d cnt=1", 100);

        // Four signed beats: 10 - 3 + 7 + 1 = 15.
        issue(1'b1, 1'b0, 32'd10);
        issue(1'b1, 1'b0, -32'sd3);
        issue(1'b1, 1'b0, 32'd7);
        issue(1'b1, 1'b1, 32'd1);
        idle(2);
        chk("four_early", 32'(out_valid), 32'd0);
        idle(1);
        chk_out("four", 32'd15, 32'd4, 1'b0);
        idle(1);
        chk("four_pulse", 32'(out_valid), 32'd0);
        $display("txn four-beat: data=15 cnt=4");

        // Positive and negative saturation.
        idle(1);
        issue(1'b1, 1'b0, 32'h7FFF_FFF0);
        issue(1'b1, 1'b1, 32'h0000_0020);
        idle(3);
        chk_out("satpos", 32'h7FFF_FFFF, 32'd2, 1'b1);
        idle(2);
        issue(1'b1, 1'b0, 32'h8000_0000);
        issue(1'b1, 1'b1, 32'hFFFF_FFFF);
        idle(3);
        chk_out("satneg", 32'h8000_0000, 32'd2, 1'b1);
        idle(2);
        $display("txn saturation: pos=7fffffff neg=80000000");

        // Backpressure: A=5 held, then B=2+4 parks in the pending slot.
        out_ready = 1'b0;
        issue(1'b1, 1'b1, 32'd5);
        issue(1'b1, 1'b0, 32'd2);
        issue(1'b1, 1'b1, 32'd4);
        idle(1);
        chk_out("bp_a", 32'd5, 32'd1, 1'b0);
        chk("bp_stall", 32'(stall), 32'd1);
        idle(3);
        chk_out("bp_a_hold", 32'd5, 32'd1, 1'b0);
        chk("bp_stall_hold", 32'(stall), 32'd1);
        out_ready = 1'b1;
        idle(1);
        chk_out("bp_b", 32'd6, 32'd2, 1'b0);
        chk("bp_b_stall", 32'(stall), 32'd1);
        idle(1);
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_stall_lo", 32'(stall), 32'd0);
        chk("bp_drop", 32'(drop_err), 32'd0);
        $display("txn backpressure: A=5 B=6");

        // Protocol violation: extra beat while B is pending.
        idle(1);
        out_ready = 1'b0;
        issue(1'b1, 1'b1, 32'd5);
        issue(1'b1, 1'b0, 32'd2);
        issue(1'b1, 1'b1, 32'd4);
        issue(1'b1, 1'b1, 32'd99);
        idle(3);
        chk("viol_drop", 32'(drop_err), 32'd1);
        chk_out("viol_a", 32'd5, 32'd1, 1'b0);
        out_ready = 1'b1;
        idle(1);
        chk_out("viol_b", 32'd6, 32'd2, 1'b0);
        idle(1);
        chk("viol_drained", 32'(out_valid), 32'd0);
        chk("viol_drop_sticky", 32'(drop_err), 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("viol_drop_clr", 32'(drop_err), 32'd0);
        $display("txn violation: drop_err set then cleared by rst");

        // Mid-operation reset with acc=50 and two beats in flight.
        idle(1);
        issue(1'b1, 1'b0, 32'd20);
        issue(1'b1, 1'b0, 32'd30);
        issue(1'b1, 1'b0, 32'd11);
        issue(1'b1, 1'b1, 32'd12);
        issue(1'b0, 1'b0, '0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("midrst_quiet", 32'(out_valid), 32'd0);
            idle(1);
        end
        issue(1'b1, 1'b1, 32'd9);
        idle(3);
        chk_out("midrst_after", 32'd9, 32'd1, 1'b0);
        $display("txn mid-reset: data=9 cnt=1");
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_tree_accumulator.md
Name: adder_tree_accumulator

Overview:
- Consumes the final-level 16-lane reduced sum from the PE adder tree.
- Accumulates it over a variable number of beats, delimited by a last flag, using signed saturating arithmetic.
- Presents each completed dot-product result on a valid/ready output port.
- Aligns its own valid/last sideband with the adder tree's fixed pipeline latency and generates a stall back to the operand feeder.

Parameters:
- ACC_BW, 32, width of tree sum, accumulator and output result (signed two's complement).
- TREE_LAT, 2, adder tree latency in cycles from operand presentation to final sum; must be >= 1.
- CNT_BW, 8, width of the beat counter reported with each result.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- tree_valid_in  input  1  asserted in the same cycle operands are driven into the adder tree.
- tree_last_in  input  1  qualifies tree_valid_in; marks the final beat of one accumulation.
- tree_sum  input  ACC_BW  adder tree final-level sum; valid TREE_LAT cycles after the matching tree_valid_in.
- stall  output  1  feeder must not assert tree_valid_in while high.
- out_data  output  ACC_BW  completed saturated accumulation.
- out_cnt  output  CNT_BW  number of beats in out_data (saturates at all-ones).
- out_sat  output  1  at least one saturation event occurred in this accumulation.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- drop_err  output  1  sticky error; cleared only by rst.

Behaviour:
- Reset (rst high at a clock edge): clears all state. Cleared state: delay line, accumulator, counter, pending, out_valid, out_data, out_cnt, out_sat, drop_err and stall, all to 0. Reset takes priority over every other event, including in-flight beats, which are discarded.
- Alignment: a TREE_LAT-deep shift register carries {valid, last}. Its output (a_valid, a_last) is cycle-aligned with tree_sum. tree_last_in is ignored when tree_valid_in is low.
- Accumulate, on a_valid with pending=0:
  - Compute nxt = (cnt==0 ? tree_sum : acc + tree_sum) in ACC_BW+1 bits.
  - Clamp nxt to [-2^(ACC_BW-1), 2^(ACC_BW-1)-1]; a clamp sets sat.
  - cnt increments and saturates at 2^CNT_BW-1.
- Completion: on a_valid and a_last, the final value (including the current beat) is the result.
  - If the output register is empty, or is draining this cycle (out_valid and out_ready): load out_data/out_cnt/out_sat next cycle, set out_valid, clear acc/cnt/sat.
  - Otherwise: hold the final value in acc, set pending=1.
- Pending: when the output drains (out_valid and out_ready) while pending=1, the output register loads from acc/cnt/sat, out_valid stays 1, acc/cnt/sat clear and pending clears.
- Illegal beat: any a_valid while pending=1 is discarded and sets drop_err. The accumulator is unchanged.
- Output handshake:
  - out_data, out_cnt and out_sat are stable while out_valid and not out_ready.
  - out_valid clears after acceptance unless a new result loads in the same cycle.
  - Back-to-back results are allowed at one per cycle.
- Stall: registered; stall = out_valid or pending, evaluated on next-state values. This guarantees that at most TREE_LAT in-flight beats arrive after stall rises, and that at most one result is pending.
- Latency: from tree_valid_in with last to out_valid is TREE_LAT+1 cycles when the output is free.
- No combinational path from out_ready to stall or out_valid.

Test Plan:
- Single-beat accumulation: valid+last, tree_sum=100, out_ready=1 -> out_valid high 3 cycles after valid (TREE_LAT=2), out_data=100, out_cnt=1, out_sat=0.
- Four-beat signed accumulation: sums 10, -3, 7, 1 with last on the 4th beat -> out_data=15, out_cnt=4; out_valid pulses one cycle.
- Positive saturation: sums 0x7FFFFFF0 then 0x20 (last) -> out_data=0x7FFFFFFF, out_sat=1. Negative case: 0x80000000 then -1 (last) -> out_data=0x80000000, out_sat=1.
- Backpressure, setup:
  - out_ready=0 with result A=5 held.
  - Feeder issued beats before stall rose: 2 and 4 (last).
- Backpressure, required response:
  - pending=1 with B=6.
  - A is stable until out_ready=1.
  - Next cycle out_data=6, out_valid=1.
  - drop_err stays 0.
- Protocol violation: with pending=1, inject an extra aligned valid beat -> drop_err=1 and stays 1, pending result unchanged; rst then clears drop_err.
- Mid-operation reset: two beats in the delay line, accumulator=50 -> rst for one cycle -> no out_valid ever appears for those beats. A subsequent single beat 9 (last) gives out_data=9, out_cnt=1.
